// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and command sequencer for a single-port word memory.
// Latency accept->resp 4 cycles with an idle memory (1 for out-of-range); one request in flight, req_ready only in IDLE.
module mem_arbiter #(
  parameter int MEM_WORDS = 2048,
  parameter int TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic [1:0]  req_ready,
  output logic [1:0]  resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_cmd_start,
  output logic        mem_cmd_write,
  input  logic        mem_cmd_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdata_ready
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, RESP_ERR} state_t;

  localparam int              CW         = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LAST   = CW'(TIMEOUT - 1);
  localparam logic [31:0]     ADDR_LIMIT = 32'(MEM_WORDS);

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          port_q, port_d;
  logic          write_q, write_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    resp_valid_q, resp_valid_d;
  logic          resp_err_q, resp_err_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;

  logic          grant_vld;
  logic          grant;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;

  // On a tie the port that did not win last time is served.
  always_comb begin
    grant_vld = |req_valid;
    if (req_valid == 2'b11) grant = ~last_grant_q;
    else                    grant = req_valid[1];
    sel_addr  = grant ? req_addr[63:32]  : req_addr[31:0];
    sel_wdata = grant ? req_wdata[63:32] : req_wdata[31:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      resp_valid_q <= '0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    resp_valid_d = '0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          last_grant_d = grant;
          port_d       = grant;
          write_d      = grant ? req_write[1] : 1'b0;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          cnt_d        = '0;
          if (sel_addr >= ADDR_LIMIT) begin
            state_d      = RESP_ERR;
            resp_valid_d = grant ? 2'b10 : 2'b01;
            resp_err_d   = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (mem_cmd_ready) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        // Completion on the last permitted cycle still wins over the timeout.
        if (mem_rdata_ready) begin
          state_d      = RESP;
          resp_valid_d = port_q ? 2'b10 : 2'b01;
          resp_rdata_d = write_q ? 32'h0 : mem_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = RESP_ERR;
          resp_valid_d = port_q ? 2'b10 : 2'b01;
          resp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:     state_d = IDLE;
      RESP_ERR: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = '0;
    if (state_q == IDLE && grant_vld) req_ready = grant ? 2'b10 : 2'b01;
    mem_cmd_start = (state_q == ISSUE);
    mem_cmd_write = write_q;
    mem_addr      = addr_q;
    mem_wdata     = wdata_q;
    resp_valid    = resp_valid_q;
    resp_err      = resp_err_q;
    resp_rdata    = resp_rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a one-cycle stub memory that can stall or never complete.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_cmd_start;
  logic        mem_cmd_write;
  logic        mem_cmd_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_rdata_ready = 1'b0;

  mem_arbiter #(.MEM_WORDS(2048), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_cmd_start(mem_cmd_start), .mem_cmd_write(mem_cmd_write),
    .mem_cmd_ready(mem_cmd_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdata_ready(mem_rdata_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub memory: unwritten words read back as 0xC0DE000 followed by addr[3:0].
  logic        stall = 1'b0;
  logic        never_complete = 1'b0;
  logic        pend = 1'b0;
  logic [15:0] written = 16'h0;
  logic [31:0] smem [16];
  int          start_cnt = 0;

  assign mem_cmd_ready = !pend && !stall;

  always @(posedge clk) begin
    if (mem_cmd_start) start_cnt <= start_cnt + 1;
    if (pend) begin
      pend <= 1'b0;
      if (!never_complete) begin
        mem_rdata_ready <= 1'b1;
        if (mem_cmd_write) begin
          smem[mem_addr[3:0]]    <= mem_wdata;
          written[mem_addr[3:0]] <= 1'b1;
        end else begin
          mem_rdata <= written[mem_addr[3:0]] ? smem[mem_addr[3:0]]
                                              : {28'hC0DE000, mem_addr[3:0]};
        end
      end
    end else if (mem_cmd_start && mem_cmd_ready) begin
      pend            <= 1'b1;
      mem_rdata_ready <= 1'b0;
    end
  end

  typedef struct {
    logic [1:0]  vld;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   resp_seen = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && resp_valid != 2'b00) begin
      exp_t e;
      resp_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'(resp_valid), 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_port",  32'(resp_valid), 32'(e.vld));
        chk("resp_err",   32'(resp_err),   32'(e.err));
        chk("resp_rdata", resp_rdata,      e.rdata);
        chk("resp_cycle", 32'(cyc),        32'(e.cyc));
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_resp_valid"}, 32'(resp_valid),    32'h0);
    chk({tag, "_resp_rdata"}, resp_rdata,         32'h0);
    chk({tag, "_resp_err"},   32'(resp_err),      32'h0);
    chk({tag, "_cmd_start"},  32'(mem_cmd_start), 32'h0);
    chk({tag, "_cmd_write"},  32'(mem_cmd_write), 32'h0);
    chk({tag, "_mem_addr"},   mem_addr,           32'h0);
    chk({tag, "_mem_wdata"},  mem_wdata,          32'h0);
  endtask

  task automatic push_exp(input logic [1:0] vld, input logic err,
                          input logic [31:0] rd, input int at);
    exp_t e;
    e.vld = vld; e.err = err; e.rdata = rd; e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic do_req(input int p, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input bit push, input logic err,
                        input logic [31:0] rd, input int lat);
    int waited = 0;
    @(negedge clk);
    req_valid[p] = 1'b1;
    req_write[p] = wr;
    req_addr[p*32 +: 32]  = a;
    req_wdata[p*32 +: 32] = wd;
    #1;
    while (!req_ready[p] && waited < 50) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!req_ready[p]) begin
      chk("grant_wait", 32'(req_ready), 32'(1 << p));
    end else if (push) begin
      push_exp((p == 1) ? 2'b10 : 2'b01, err, rd, cyc + lat);
    end
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int waited;
    int starts;
    int seen;
    rst_n = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    rst_n = 1'b1;

    // Both ports request continuously: grants alternate starting with port 0.
    @(negedge clk);
    req_valid = 2'b11; req_write = 2'b00;
    req_addr  = {32'd11, 32'd10};
    #1;
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      while (req_ready == 2'b00 && waited < 50) begin
        @(negedge clk); #1;
        waited++;
      end
      chk("rr_grant", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k % 2 == 0) push_exp(2'b01, 1'b0, 32'hC0DE000A, cyc + 4);
      else            push_exp(2'b10, 1'b0, 32'hC0DE000B, cyc + 4);
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    drain();

    // Port 1 write then read-back of the same word.
    do_req(1, 1'b1, 32'd5, 32'h11223344, 1'b1, 1'b0, 32'h0, 4);
    drain();
    do_req(1, 1'b0, 32'd5, 32'h0, 1'b1, 1'b0, 32'h11223344, 4);
    drain();

    // Port 0 write is demoted to a read.
    do_req(0, 1'b1, 32'd5, 32'hDEADBEEF, 1'b1, 1'b0, 32'h11223344, 4);
    drain();

    // Address bounds: first invalid word errors without touching memory, last valid word works.
    starts = start_cnt;
    do_req(0, 1'b0, 32'd2048, 32'h0, 1'b1, 1'b1, 32'h0, 1);
    drain();
    chk("oor_no_cmd_start", 32'(start_cnt - starts), 32'h0);
    do_req(1, 1'b0, 32'd2047, 32'h0, 1'b1, 1'b0, 32'hC0DE000F, 4);
    drain();

    // Memory not ready for three ISSUE cycles.
    stall = 1'b1;
    do_req(1, 1'b0, 32'd10, 32'h0, 1'b1, 1'b0, 32'hC0DE000A, 7);
    repeat (3) begin
      @(negedge clk);
      chk("stall_cmd_start", 32'(mem_cmd_start), 32'h1);
      chk("stall_mem_addr",  mem_addr,           32'd10);
    end
    @(posedge clk); #1;
    stall = 1'b0;
    drain();

    // Memory never completes: error after 16 WAIT cycles, then normal service resumes.
    never_complete = 1'b1;
    do_req(0, 1'b0, 32'd11, 32'h0, 1'b1, 1'b1, 32'h0, 18);
    drain();
    never_complete = 1'b0;
    do_req(1, 1'b0, 32'd11, 32'h0, 1'b1, 1'b0, 32'hC0DE000B, 4);
    drain();

    // Reset during WAIT drops the access silently and restores port 0 priority.
    do_req(1, 1'b0, 32'd11, 32'h0, 1'b0, 1'b0, 32'h0, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    seen = resp_seen;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("midreset_no_resp", 32'(resp_seen - seen), 32'h0);
    req_valid = 2'b11; req_write = 2'b00;
    req_addr  = {32'd11, 32'd10};
    #1;
    chk("midreset_tie_grant", 32'(req_ready), 32'h1);
    push_exp(2'b01, 1'b0, 32'hC0DE000A, cyc + 4);
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();
    repeat (3) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter/sequencer in front of the single-port word memory (cmd_start/cmd_ready/rdata_ready handshake).
- Port 0 is instruction/bytecode fetch. Port 1 is data/stack access.
- Grants one request at a time with round-robin fairness and drives the memory command sequence.
- Returns a one-cycle response pulse per request, with bounds and timeout errors.

Parameters:
MEM_WORDS, 2048, number of 32-bit words in the memory; valid word addresses are 0..MEM_WORDS-1
TIMEOUT, 16, maximum cycles in WAIT before an access is aborted with error

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  2  per-port request valid (bit i = port i)
req_write  input  2  per-port write flag (port 0 write requests are treated as reads)
req_addr  input  64  per-port word address ([31:0] port 0, [63:32] port 1)
req_wdata  input  64  per-port write data, same packing as req_addr
req_ready  output  2  combinational one-hot; request accepted this cycle
resp_valid  output  2  registered one-hot, one-cycle response pulse
resp_rdata  output  32  read data, valid with resp_valid
resp_err  output  1  error flag, valid with resp_valid
mem_cmd_start  output  1  memory command start
mem_cmd_write  output  1  memory write flag
mem_cmd_ready  input  1  memory idle
mem_addr  output  32  memory word address
mem_wdata  output  32  memory write data
mem_rdata  input  32  memory read data
mem_rdata_ready  input  1  memory completion level (cleared on command accept, set on completion)

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE. last_grant=1, so port 0 wins the first tie.
  - All outputs are 0: resp_valid=0, resp_rdata=0, resp_err=0, mem_cmd_start=0, mem_cmd_write=0, mem_addr=0, mem_wdata=0.
  - Timeout counter is 0.
- Reset mid-access: the in-flight request is dropped and no response is produced. The memory may still complete; that completion is ignored.
- IDLE:
  - If any req_valid is set, grant one port: a single requester wins; if both, the port != last_grant wins.
  - req_ready[g]=1 combinationally in IDLE only. Latch port id, write (forced 0 for port 0), addr and wdata, and update last_grant=g.
  - If addr >= MEM_WORDS, go to RESP_ERR. Otherwise go to ISSUE.
  - No req_ready is asserted in any other state.
- ISSUE:
  - mem_cmd_start=1 with the latched mem_addr, mem_wdata and mem_cmd_write.
  - If mem_cmd_ready=1, go to WAIT and drop mem_cmd_start next cycle. Otherwise hold ISSUE with all signals stable.
- WAIT:
  - mem_addr and mem_wdata are held stable until completion, because the memory samples write data late.
  - The counter increments each cycle. When mem_rdata_ready=1, latch mem_rdata and go to RESP.
  - If the counter reaches TIMEOUT with no completion, go to RESP_ERR.
- RESP:
  - resp_valid[port]=1 for exactly one cycle, with resp_err=0.
  - resp_rdata = latched data for reads. For writes resp_rdata=0.
  - Return to IDLE. A new grant is possible in the same cycle RESP is left, i.e. the next cycle.
- RESP_ERR:
  - resp_valid[port]=1 for one cycle, with resp_err=1 and resp_rdata=0. Then go to IDLE.
  - An out-of-range request never asserts mem_cmd_start.
- Latency with the memory idle:
  - Accept at cycle T; mem_cmd_start at T+1; mem_rdata_ready at T+3; resp_valid at T+4.
  - Peak throughput is one access per 5 cycles.
  - Out-of-range: resp_valid at T+1.
- Requester side:
  - A requester must hold req_* until req_ready.
  - Dropping req_valid before a grant is legal; no response is produced.
- resp_valid and req_ready of the same port may both be high in one cycle only if the requester re-requests; that is legal.

Test Plan:
1. Port 1 writes addr 5, data 0x11223344, then port 1 reads addr 5 -> read resp_valid=2'b10 at T+4 after accept, resp_rdata=0x11223344 (byte order preserved round-trip), resp_err=0.
2. Both ports request continuously after reset -> grants alternate 0,1,0,1. The first grant is port 0. Each response goes only to the granted port.
3. Port 0 reads addr 2048 (MEM_WORDS=2048) -> resp_valid=2'b01 at T+1, resp_err=1, resp_rdata=0, mem_cmd_start never asserted.
4. mem_cmd_ready held 0 for 3 cycles in ISSUE -> mem_cmd_start stays 1 with stable mem_addr; the access completes normally once ready.
5. Stub memory never raises mem_rdata_ready -> after TIMEOUT=16 WAIT cycles, resp_err=1 pulse, return to IDLE, next request granted.
6. Assert rst_n=0 during WAIT -> all outputs 0 immediately, no resp_valid after release, port 0 wins the next tie.
